// File: rtl/apb_regfile_slave.sv
// APB completer exposing a bank of read/write registers with fixed wait states.
// Register 0 is a read-only ID; out-of-range or misaligned accesses answer PSLVERR.
module apb_regfile_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           NUM_REGS    = 16,
   parameter int unsigned           WAIT_CYCLES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA9B0_0001
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  reg_we;

   logic [IdxW-1:0]       setup_idx;
   logic                  setup_err;
   logic [DATA_WIDTH-1:0] setup_rdata;
   logic [DATA_WIDTH-1:0] held_rdata;

   assign setup_idx = PADDR[IdxW+1:2];
   assign setup_err = ((PADDR >> 2) >= ADDR_WIDTH'(NUM_REGS)) || (PADDR[1:0] != 2'b00);

   // Read data is selected from live bus values when there are no wait states,
   // otherwise from the values latched at setup.
   always_comb begin
      setup_rdata = '0;
      held_rdata  = '0;
      if (!PWRITE && !setup_err) begin
         setup_rdata = (setup_idx == '0) ? ID_VALUE : regs_q[setup_idx];
      end
      if (!wr_q && !err_q) begin
         held_rdata = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      err_d     = err_q;
      wdata_d   = wdata_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      reg_we    = 1'b0;

      unique case (state_q)
         StIdle: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            if (PSEL && !PENABLE) begin
               idx_d   = setup_idx;
               wr_d    = PWRITE;
               err_d   = setup_err;
               wdata_d = PWDATA;
               if (WAIT_CYCLES == 0) begin
                  state_d   = StResp;
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  prdata_d  = setup_rdata;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end

         StWait: begin
            if (!PSEL) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (PENABLE) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = StResp;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = held_rdata;
               end
            end
         end

         StResp: begin
            if (!PSEL || PENABLE) begin
               // Completion and abort share the exit; only completion may write.
               reg_we    = PSEL && wr_q && !err_q && (idx_q != '0);
               state_d   = StIdle;
               cnt_d     = '0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         end

         default: begin
            state_d   = StIdle;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         regs_q[idx_q] <= wdata_q;
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: two completers (0 and 3 wait states) share the bus, each with its own PSEL.
module tb_apb_regfile_slave;

   localparam logic [31:0] IdVal = 32'hA9B0_0001;
   localparam int          Wait1 = 3;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
   } exp_t;

   logic        PCLK    = 1'b0;
   logic        PRESETn = 1'b0;
   logic [31:0] paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [1:0]  psel    = '0;

   logic [31:0] prdata0, prdata1, prdata_m;
   logic        pready0, pready1, pready_m;
   logic        pslverr0, pslverr1, pslverr_m;
   int          cur = 0;

   exp_t        sb[$];
   logic [31:0] mdl [2][16];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 PCLK = ~PCLK;

   assign prdata_m  = (cur == 1) ? prdata1  : prdata0;
   assign pready_m  = (cur == 1) ? pready1  : pready0;
   assign pslverr_m = (cur == 1) ? pslverr1 : pslverr0;

   apb_regfile_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(IdVal)
   ) dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb_regfile_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(Wait1), .ID_VALUE(IdVal)
   ) dut1 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) mdl[d][i] = '0;
      end
   endtask

   // One full transfer on completer d. Leaves the bus at completion+1 so callers
   // may start the next setup immediately (back-to-back).
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
      exp_t        e;
      exp_t        got;
      logic [31:0] idx;
      int          cyc;
      logic        done;
      idx   = addr >> 2;
      e.err = (idx >= 16) || (addr[1:0] != 2'b00);
      e.rd  = (wr || e.err) ? 32'h0 : ((idx == 0) ? IdVal : mdl[d][idx[3:0]]);
      e.lat = (d == 1) ? 2 + Wait1 : 2;
      sb.push_back(e);

      cur     = d;
      psel    = (d == 1) ? 2'b10 : 2'b01;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      step();
      // Scramble the bus during access; the latched setup values must win.
      penable = 1'b1;
      pwrite  = ~wr;
      paddr   = addr ^ 32'h4;
      pwdata  = ~wdata;
      cyc     = 2;
      done    = 1'b0;
      while (!done && cyc < 20) begin
         if (pready_m) begin
            done = 1'b1;
         end else begin
            check("slverr_without_ready", 32'(pslverr_m), 32'h0);
            step();
            cyc++;
         end
      end
      check("completed", 32'(done), 32'h1);
      got = sb.pop_front();
      check("rdata", prdata_m, got.rd);
      check("slverr", 32'(pslverr_m), 32'(got.err));
      check("latency", 32'(cyc), 32'(got.lat));
      if (wr && !e.err && idx != 0) mdl[d][idx[3:0]] = wdata;
      step();
      check("ready_drop", 32'(pready_m), 32'h0);
      psel    = '0;
      penable = 1'b0;
   endtask

   initial begin
      clear_model();

      // Reset
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_ready0", 32'(pready0), 32'h0);
      check("rst_slverr0", 32'(pslverr0), 32'h0);
      check("rst_rdata0", prdata0, 32'h0);
      check("rst_ready1", 32'(pready1), 32'h0);
      check("rst_rdata1", prdata1, 32'h0);
      PRESETn = 1'b1;
      step();
      xfer(0, 1'b0, 32'h14, 32'h0);

      // Zero wait states: write then read back
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF);
      step();
      xfer(0, 1'b0, 32'h08, 32'h0);

      // Three wait states, read-only ID register
      xfer(1, 1'b0, 32'h00, 32'h0);
      xfer(1, 1'b1, 32'h00, 32'h1234);
      xfer(1, 1'b0, 32'h00, 32'h0);

      // Error responses; index 16 and 17 alias to 0 and 1 if decoded carelessly
      xfer(0, 1'b1, 32'h40, 32'hCAFE0000);
      xfer(0, 1'b0, 32'h06, 32'h0);
      xfer(0, 1'b1, 32'h44, 32'hBAD00001);
      xfer(0, 1'b1, 32'h0A, 32'hBAD00002);
      xfer(0, 1'b0, 32'h04, 32'h0);
      xfer(0, 1'b0, 32'h08, 32'h0);

      // Back-to-back on both completers
      for (int d = 0; d < 2; d++) begin
         xfer(d, 1'b1, 32'h04, 32'h1);
         xfer(d, 1'b1, 32'h08, 32'h2);
         xfer(d, 1'b1, 32'h0C, 32'h3);
         xfer(d, 1'b0, 32'h04, 32'h0);
         xfer(d, 1'b0, 32'h08, 32'h0);
         xfer(d, 1'b0, 32'h0C, 32'h0);
         step();
      end

      // PENABLE without a setup phase is ignored
      cur     = 0;
      psel    = 2'b01;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 32'h04;
      step();
      check("no_setup_ready_a", 32'(pready_m), 32'h0);
      step();
      check("no_setup_ready_b", 32'(pready_m), 32'h0);
      psel    = '0;
      penable = 1'b0;
      step();

      // Abort during WAIT: the write must not land
      xfer(1, 1'b1, 32'h10, 32'h77);
      step();
      cur     = 1;
      psel    = 2'b10;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'h55;
      step();
      penable = 1'b1;
      step();
      check("abort_wait_ready", 32'(pready_m), 32'h0);
      psel    = '0;
      penable = 1'b0;
      step();
      check("abort_ready", 32'(pready_m), 32'h0);
      xfer(1, 1'b0, 32'h10, 32'h0);

      // Reset asserted during WAIT of a write
      cur     = 1;
      psel    = 2'b10;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'h99;
      step();
      penable = 1'b1;
      step();
      PRESETn = 1'b0;
      #1;
      check("rst_wait_ready", 32'(pready_m), 32'h0);
      check("rst_wait_slverr", 32'(pslverr_m), 32'h0);
      psel    = '0;
      penable = 1'b0;
      clear_model();
      step();
      PRESETn = 1'b1;
      step();
      xfer(1, 1'b0, 32'h10, 32'h0);
      xfer(0, 1'b0, 32'h08, 32'h0);

      // Reset asserted while a read response is on the bus clears outputs at once
      cur     = 1;
      psel    = 2'b10;
      pwrite  = 1'b0;
      paddr   = 32'h00;
      step();
      penable = 1'b1;
      repeat (Wait1) step();
      check("resp_ready", 32'(pready_m), 32'h1);
      check("resp_rdata", prdata_m, IdVal);
      #2;
      PRESETn = 1'b0;
      #1;
      check("rst_resp_ready", 32'(pready_m), 32'h0);
      check("rst_resp_rdata", prdata_m, 32'h0);
      check("rst_resp_slverr", 32'(pslverr_m), 32'h0);
      psel    = '0;
      penable = 1'b0;
      step();
      PRESETn = 1'b1;
      step();
      xfer(1, 1'b0, 32'h00, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
